apb_slave_mem: RTL



---
 rtl/apb_slave_pkg.sv | 26 ++
 rtl/apb_slave_ram.sv | 26 ++
 rtl/apb_slave_mem.sv | 135 +++++++++++++
 3 files changed

// File: rtl/apb_slave_pkg.sv
// Shared types and the access-error rule for the APB completer memory.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OKAY   = 1'b0,
        SLVERR = 1'b1
    } resp_t;

    localparam int unsigned MEM_DEPTH_DEF = 64;
    localparam int unsigned RO_BASE_DEF   = 48;

    // An access errors when it falls outside the memory, or writes the read-only top region.
    function automatic logic is_err(input logic [31:0] addr,
                                    input logic        write,
                                    input int unsigned depth   = MEM_DEPTH_DEF,
                                    input int unsigned ro_base = RO_BASE_DEF);
        return (addr >= depth) || (write && (addr >= ro_base));
    endfunction

endpackage

// File: rtl/apb_slave_ram.sv
// Single-port word memory: synchronous write, asynchronous read, never reset.
module apb_slave_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Contents persist across bus reset, so the write port has no reset term.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word memory, with programmable wait states and
// out-of-range / read-only error responses.
module apb_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MEM_DEPTH   = 64,
    parameter int unsigned RO_BASE     = 48,
    parameter int unsigned WAIT_CYCLES = 2    // 0..15, held in a 4-bit counter
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int unsigned RAM_AW = $clog2(MEM_DEPTH);

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;
    logic                  pready_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    resp_t                 resp_q;

    logic                  setup_err;
    logic                  ram_we;
    logic [RAM_AW-1:0]     ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign setup_err = is_err(32'(PADDR), PWRITE, MEM_DEPTH, RO_BASE);

    // In IDLE the read port looks at the live bus address so a zero-wait read
    // can register its data at the setup edge; otherwise the latched address.
    assign ram_raddr = (state_q == IDLE) ? RAM_AW'(PADDR) : RAM_AW'(addr_q);

    // Commit only at the completion edge of a legal write; reset suppresses it.
    assign ram_we = (state_q == DONE) && PSELx && PENABLE && pready_q &&
                    write_q && !err_q && !PRESET;

    apb_slave_ram #(
        .DEPTH (MEM_DEPTH),
        .DW    (DATA_WIDTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk_i   (PCLK),
        .we_i    (ram_we),
        .waddr_i (RAM_AW'(addr_q)),
        .wdata_i (wdata_q),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Transfer FSM: setup latch, wait-state countdown, registered response.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            pready_q <= 1'b0;
            prdata_q <= '0;
            resp_q   <= OKAY;
        end else begin
            case (state_q)
                IDLE: begin
                    // A lone PENABLE without a setup phase is ignored here.
                    if (PSELx && !PENABLE) begin
                        addr_q  <= PADDR;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                        err_q   <= setup_err;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            state_q  <= DONE;
                            pready_q <= 1'b1;
                            resp_q   <= setup_err ? SLVERR : OKAY;
                            prdata_q <= (!PWRITE && !setup_err) ? ram_rdata : '0;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!PSELx) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (PENABLE) begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q  <= DONE;
                            pready_q <= 1'b1;
                            resp_q   <= err_q ? SLVERR : OKAY;
                            prdata_q <= (!write_q && !err_q) ? ram_rdata : '0;
                        end
                    end
                end
                DONE: begin
                    // Completion and abort both drop the response and go idle.
                    if (!PSELx || PENABLE) begin
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        pready_q <= 1'b0;
                        prdata_q <= '0;
                        resp_q   <= OKAY;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= '0;
                    pready_q <= 1'b0;
                    prdata_q <= '0;
                    resp_q   <= OKAY;
                end
            endcase
        end
    end

    assign PREADY  = pready_q;
    assign PRDATA  = prdata_q;
    assign PSLVERR = resp_q;

endmodule
